// File: rtl/viterbi_tbck_frame.sv
// rtl/viterbi_tbck_frame.sv - frame-based Viterbi traceback with valid/ready on both sides
//
// Collects one survivor-decision vector per trellis step for a full frame,
// traces back from state 0 (terminated) or best_st, then emits the decoded
// bits in forward order as OUT_W-bit words.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   term_mode   1: trace from state 0, 0: trace from best_st (sampled on last beat)
//   dec_valid   decision vector valid
//   dec_ready   block accepts decision vectors (FILL state)
//   dec_in      survivor decisions, bit s selects the predecessor of state s
//   best_st     lowest-metric state, used on the last beat only
//   out_valid   data_out valid
//   out_ready   sink accepts data_out
//   data_out    decoded word, bit 0 is the earliest bit
//   frame_done  one-cycle pulse after the last word of a frame is accepted
module viterbi_tbck_frame #(
  parameter int K         = 3,
  parameter int FRAME_LEN = 16,
  parameter int OUT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      term_mode,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [(1 << (K-1))-1:0]   dec_in,
  input  logic [K-2:0]              best_st,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          data_out,
  output logic                      frame_done
);

  localparam int SW = K - 1;
  localparam int NS = 1 << SW;
  localparam int PW = $clog2(FRAME_LEN);
  localparam int NW = FRAME_LEN / OUT_W;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(FRAME_LEN - 1);
  localparam logic [WW-1:0] LAST_W   = WW'(NW - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRACE = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_tb_ptr;
  logic [SW-1:0]         r_cur_st;
  logic [WW-1:0]         r_w;
  logic [NS-1:0]         r_mem [FRAME_LEN];
  logic [FRAME_LEN-1:0]  r_bits;
  logic                  r_frame_done;

  logic                  w_in_fire;
  logic                  w_last_in;
  logic                  w_tb_last;
  logic                  w_out_fire;
  logic                  w_last_out;
  logic                  w_dec_bit;
  logic [SW-1:0]         w_next_st;
  logic [NW-1:0][OUT_W-1:0] w_words;

  assign w_in_fire  = (r_state == S_FILL) && dec_valid;
  assign w_last_in  = w_in_fire && (r_wr_ptr == LAST_PTR);
  assign w_tb_last  = (r_state == S_TRACE) && (r_tb_ptr == '0);
  assign w_out_fire = (r_state == S_OUT) && out_ready;
  assign w_last_out = w_out_fire && (r_w == LAST_W);

  // Predecessor: shift the state left, the stored decision becomes the new LSB
  // (the oldest input bit). The cast drops the departing MSB.
  assign w_dec_bit = r_mem[r_tb_ptr][r_cur_st];
  assign w_next_st = SW'({r_cur_st, w_dec_bit});

  // Word view of the bit buffer; word 0 holds the earliest bits.
  assign w_words  = r_bits;
  assign data_out = (r_state == S_OUT) ? w_words[r_w] : '0;

  assign frame_done = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dec_ready   = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_FILL: begin
        dec_ready = 1'b1;
        if (w_last_in) begin
          w_state_nxt = S_TRACE;
        end
      end
      S_TRACE: begin
        if (w_tb_last) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (w_last_out) begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_tb_ptr     <= '0;
      r_cur_st     <= '0;
      r_w          <= '0;
      r_bits       <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_frame_done <= w_last_out;
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_mem[r_wr_ptr] <= dec_in;
            if (w_last_in) begin
              r_wr_ptr <= '0;
              r_tb_ptr <= LAST_PTR;
              r_cur_st <= term_mode ? '0 : best_st;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        S_TRACE: begin
          // The MSB of the state is the input bit decided at this step.
          r_bits[r_tb_ptr] <= r_cur_st[SW-1];
          r_cur_st         <= w_next_st;
          if (w_tb_last) begin
            r_w <= '0;
          end else begin
            r_tb_ptr <= r_tb_ptr - 1'b1;
          end
        end
        S_OUT: begin
          if (w_out_fire) begin
            r_w <= w_last_out ? '0 : r_w + 1'b1;
          end
        end
        default: begin
          r_wr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_tbck_frame.sv
// tb/tb_viterbi_tbck_frame.sv - directed table-driven bench for viterbi_tbck_frame
module tb_viterbi_tbck_frame;

  logic       clk;
  logic       rst;
  logic       term_mode;
  logic       dec_valid;
  logic       dec_ready;
  logic [3:0] dec_in;
  logic [1:0] best_st;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int n_fd   = 0;
  int n_frames = 0;

  viterbi_tbck_frame #(.K(3), .FRAME_LEN(16), .OUT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .term_mode  (term_mode),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_in     (dec_in),
    .best_st    (best_st),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_fd++;
  end

  typedef struct {
    logic [15:0] u;
    logic        term;
    logic [1:0]  best;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    int          gap;
    bit          bp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Encoder-side view: state s_t = {u_t, u_(t-1)}, survivor bit at s_t is u_(t-2).
  function automatic logic [3:0] mk_dec(input logic [15:0] u, input int t);
    logic [3:0] d;
    logic [1:0] s;
    logic       p1;
    logic       p2;
    p1 = (t >= 1) ? u[t-1] : 1'b0;
    p2 = (t >= 2) ? u[t-2] : 1'b0;
    s  = {u[t], p1};
    d  = 4'($urandom);
    d[s] = p2;
    return d;
  endfunction

  task automatic send_frame(input logic [15:0] u, input logic term, input logic [1:0] best,
                            input int gap);
    for (int t = 0; t < 16; t++) begin
      int ng;
      ng = (t == 0 || gap == 0) ? 0 : $urandom_range(gap, 0);
      repeat (ng) begin
        dec_valid = 1'b0;
        dec_in    = 4'($urandom);
        @(posedge clk); #1;
      end
      if (dec_ready !== 1'b1) chk("dec_ready_fill", dec_ready, 1);
      dec_valid = 1'b1;
      dec_in    = mk_dec(u, t);
      term_mode = (t == 15) ? term : ~term;
      best_st   = (t == 15) ? best : 2'($urandom);
      @(posedge clk); #1;
    end
    dec_valid = 1'b0;
    chk("dec_ready_drop", dec_ready, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic recv(input logic [7:0] exp0, input logic [7:0] exp1, input bit bp);
    for (int w = 0; w < 2; w++) begin
      logic [7:0] e;
      e = (w == 0) ? exp0 : exp1;
      if (bp) begin
        repeat (5) begin
          out_ready = 1'b0;
          dec_valid = 1'b1;
          dec_in    = 4'($urandom);
          chk("hold_data", data_out, e);
          chk("hold_valid", out_valid, 1);
          chk("dec_ready_out", dec_ready, 0);
          @(posedge clk); #1;
        end
        dec_valid = 1'b0;
      end
      out_ready = 1'b1;
      chk(w == 0 ? "word0" : "word1", data_out, e);
      chk("fd_early", frame_done, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("frame_done", frame_done, 1);
    chk("valid_after", out_valid, 0);
    chk("dec_ready_fd", dec_ready, 1);
  endtask

  initial begin
    int lat;
    int bad;

    vecs[0] = '{u: 16'h0000, term: 1'b1, best: 2'b00, exp0: 8'h00, exp1: 8'h00, gap: 0, bp: 1'b0};
    vecs[1] = '{u: 16'h3CA5, term: 1'b0, best: 2'b00, exp0: 8'hA5, exp1: 8'h3C, gap: 0, bp: 1'b0};
    vecs[2] = '{u: 16'h3CA5, term: 1'b1, best: 2'b11, exp0: 8'hA5, exp1: 8'h3C, gap: 0, bp: 1'b0};
    vecs[3] = '{u: 16'hF00F, term: 1'b0, best: 2'b11, exp0: 8'h0F, exp1: 8'hF0, gap: 0, bp: 1'b1};
    vecs[4] = '{u: 16'h5A96, term: 1'b0, best: 2'b01, exp0: 8'h96, exp1: 8'h5A, gap: 3, bp: 1'b0};
    vecs[5] = '{u: 16'h2B71, term: 1'b1, best: 2'b10, exp0: 8'h71, exp1: 8'h2B, gap: 3, bp: 1'b0};
    vecs[6] = '{u: 16'hC3E8, term: 1'b0, best: 2'b11, exp0: 8'hE8, exp1: 8'hC3, gap: 3, bp: 1'b1};

    rst       = 1'b1;
    term_mode = 1'b0;
    dec_valid = 1'b0;
    dec_in    = 4'h0;
    best_st   = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frames run back to back: each starts in the frame_done cycle of the previous one.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].u, vecs[i].term, vecs[i].best, vecs[i].gap);
      wait_out(lat);
      chk("latency", lat, 16);
      recv(vecs[i].exp0, vecs[i].exp1, vecs[i].bp);
      n_frames++;
    end

    // Reset while a frame is waiting in OUT.
    send_frame(vecs[1].u, vecs[1].term, vecs[1].best, 0);
    wait_out(lat);
    chk("latency_pre_rst", lat, 16);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", dec_ready, 1);
    chk("midrst_data", data_out, 0);
    chk("midrst_fd", frame_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || data_out !== 8'h00 || dec_ready !== 1'b1)
        bad++;
    end
    chk("post_rst_quiet", bad, 0);

    // Partial frame discarded by reset; the following frame must align from beat 0.
    for (int t = 0; t < 5; t++) begin
      dec_valid = 1'b1;
      dec_in    = 4'($urandom);
      @(posedge clk); #1;
    end
    dec_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(vecs[3].u, vecs[3].term, vecs[3].best, 1);
    wait_out(lat);
    chk("latency_post_rst", lat, 16);
    recv(vecs[3].exp0, vecs[3].exp1, 1'b0);
    n_frames++;

    @(posedge clk); #1;
    chk("frame_done_count", n_fd, n_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/viterbi_tbck_frame.md
# viterbi_tbck_frame

Parametrised frame-based traceback unit for the Viterbi decoder. It sits between the ACS/path-metric stage and the byte sink. Per trellis step it stores one survivor-decision vector, with one bit per state, into an internal survivor buffer. After a full frame it traces back from a selectable start state and emits the decoded bits in forward order as OUT_W-bit words on a valid/ready interface. It replaces the fixed 4-state, 8-bit traceback with a block that has:
- a generic constraint length;
- a configurable frame length;
- terminated and best-state start modes;
- flow control on both sides.

## Interface
- K, 3: constraint length. NS = 2^(K-1) states; SW = K-1 is the state width.
- FRAME_LEN, 16: trellis steps per frame. Must be a multiple of OUT_W and at least 2.
- OUT_W, 8: decoded bits per output word.

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- term_mode  in  1  1: traceback starts from state 0 (zero-tailed frame). 0: starts from best_st. Sampled on the last input beat of a frame.
- dec_valid  in  1  decision vector valid
- dec_ready  out  1  block can accept a decision vector
- dec_in  in  NS  survivor decision per state; bit s selects the predecessor of state s
- best_st  in  SW  lowest-metric state at this step; used only on the last beat of a frame
- out_valid  out  1  data_out valid
- out_ready  in  1  sink accepts data_out
- data_out  out  OUT_W  decoded word; bit 0 is the earliest decoded bit
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted

## Operation
- State convention: state after step t is s_t = {u_t, u_(t-1), ..., u_(t-SW+1)}, with the newest input in the MSB.
  - Decoded bit for step t: u_t = s_t[SW-1].
  - Predecessor: s_(t-1) = {s_t[SW-2:0], dec[t][s_t]}. For K=3: states 00/01 have predecessors 00/01 and 10/11 respectively, and states 10/11 decode as 1.
- Survivor buffer: FRAME_LEN x NS register array, written at index wr_ptr. Bit buffer: FRAME_LEN bits.
- FSM states:
  - FILL: dec_ready=1.
    - Each cycle with dec_valid & dec_ready, write dec_in to mem[wr_ptr] and increment wr_ptr.
    - On the beat where wr_ptr == FRAME_LEN-1, latch the start state (0 if term_mode, else best_st), set tb_ptr = FRAME_LEN-1, clear wr_ptr, and go to TRACE.
  - TRACE: dec_ready=0, one step per cycle.
    - bits[tb_ptr] <= cur_st[SW-1].
    - cur_st <= {cur_st[SW-2:0], mem[tb_ptr][cur_st]}.
    - tb_ptr decrements. After the tb_ptr == 0 step, set word index w = 0 and go to OUT.
  - OUT: dec_ready=0, out_valid=1, data_out = bits[w*OUT_W +: OUT_W].
    - On out_valid & out_ready, w increments.
    - On acceptance of the last word (w == FRAME_LEN/OUT_W - 1), pulse frame_done and go to FILL.
- data_out is held stable while out_valid is high and out_ready is low.
- Decision bits of non-survivor states are don't-care; they must not affect the output.

## Timing
- Reset values:
  - FSM = FILL, wr_ptr = 0, tb_ptr = 0, cur_st = 0, w = 0.
  - bits = 0, survivor buffer = 0.
  - dec_ready = 1 (combinational from FSM==FILL; asserted in reset).
  - out_valid = 0, data_out = 0, frame_done = 0.
- Input beats may have gaps (dec_valid low). wr_ptr holds through gaps.
- Last input beat at edge E:
  - TRACE occupies edges E+1 .. E+FRAME_LEN.
  - out_valid rises after edge E+FRAME_LEN; the first word is visible one cycle after the final traceback step.
- Minimum frame period: FRAME_LEN input cycles + FRAME_LEN trace cycles + FRAME_LEN/OUT_W output cycles.
- dec_ready drops in the cycle after the last input beat. A dec_valid pulse during TRACE/OUT is ignored, not stored.
- frame_done is high for exactly the cycle following the final handshake edge. dec_ready is high in that same cycle, so a new frame may begin immediately.
- rst asserted mid-frame (any state) clears everything immediately. Partial frames and undelivered words are discarded, with no spurious out_valid after release.
- Pointer widths are clog2(FRAME_LEN). There is no wrap beyond FRAME_LEN-1; FSM transitions reset the pointers.

## Test plan
- Reset check: assert rst mid-OUT → out_valid=0, dec_ready=1, data_out=0 during reset and after release, with no frame_done.
- Zero path (K=3, FRAME_LEN=16, OUT_W=8): 16 beats of dec_in=4'b0000, term_mode=1 → words 0x00, 0x00; frame_done once; first out_valid 16 cycles after the last beat.
- Known-sequence, best-state mode: inputs u = 0xA5 then 0x3C, bit 0 first.
  - Bench sets dec[t][s_t] = u_(t-2) and fills the other bits randomly.
  - best_st = s_15 = {u_15, u_14} = 2'b00, term_mode=0.
  - Required output: 0xA5 then 0x3C.
- Terminated mode: same frame but last two inputs forced to 0 and best_st driven to 2'b11 → best_st ignored, start from 0, correct words still produced.
- Backpressure: out_ready low for 5 cycles on each word → data_out stable, no word lost or duplicated; dec_valid pulses during OUT are ignored (next frame output unaffected).
- Back-to-back frames with dec_valid gaps (random 0-3 idle cycles): three frames decode correctly, and the new frame starts in the frame_done cycle.
